regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (we/A3/wd) between the pipeline writeback

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/rf_wr_fifo.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: address/data types and the
// write request carried through the long-latency result FIFO.
package kianv_rf_pkg;
  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t data;
  } rf_wr_req_t;

  localparam rf_addr_t RF_X0 = 5'd0;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback / long-latency-unit / register-file bundle. The slave modport is the arbiter;
// the master modport is the pipeline, LU and register-file side.
interface regfile_wb_arbiter_if #(parameter int REGISTER_DEPTH = 32);
  import kianv_rf_pkg::*;

  logic                      wb_valid;
  rf_addr_t                  wb_rd;
  rf_data_t                  wb_data;
  logic                      wb_stall;
  logic                      lu_valid;
  logic                      lu_ready;
  rf_addr_t                  lu_rd;
  rf_data_t                  lu_data;
  logic                      lu_issue_valid;
  rf_addr_t                  lu_issue_rd;
  logic                      rf_we;
  rf_addr_t                  rf_a3;
  rf_data_t                  rf_wd;
  logic [REGISTER_DEPTH-1:0] pending_mask;

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, lu_issue_valid, lu_issue_rd,
    output wb_stall, lu_ready, rf_we, rf_a3, rf_wd, pending_mask
  );

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, lu_issue_valid, lu_issue_rd,
    input  wb_stall, lu_ready, rf_we, rf_a3, rf_wd, pending_mask
  );
endinterface

// File: rtl/rf_wr_fifo.sv
// Small power-of-two FIFO of pending long-latency register writes. The caller guarantees
// push only when not full and pop only when not empty.
import kianv_rf_pkg::*;

module rf_wr_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_push,
  input  rf_wr_req_t i_push_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output rf_wr_req_t o_head
);
  localparam int AW = $clog2(DEPTH);

  rf_wr_req_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single RF write port between writeback (priority) and queued LU results,
// with an anti-starvation stall. Define KIANV_RF_SCOREBOARD_EN for the pending-write mask.
import kianv_rf_pkg::*;

module regfile_wb_arbiter #(
  parameter int REGISTER_DEPTH = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int MAX_WAIT       = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_wb_grant;
  logic          w_wb_stall;
  rf_wr_req_t    w_head;
  rf_wr_req_t    w_lu_req;
  logic [WW-1:0] r_wait;

  // Stall is a pure function of state so the pipeline sees it early in the cycle.
  assign w_wb_stall = (r_wait == WW'(MAX_WAIT)) && !w_empty;
  assign w_wb_grant = bus.wb_valid && !w_wb_stall;
  assign w_pop      = !w_wb_grant && !w_empty;
  assign w_push     = bus.lu_valid && !w_full && (bus.lu_rd != RF_X0);
  assign w_lu_req   = '{rd: bus.lu_rd, data: bus.lu_data};

  assign bus.wb_stall = w_wb_stall;
  assign bus.lu_ready = !w_full;

  rf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_push),
    .i_push_data (w_lu_req),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = RF_X0;
    bus.rf_wd = '0;
    if (w_wb_grant) begin
      bus.rf_we = (bus.wb_rd != RF_X0);
      bus.rf_a3 = bus.wb_rd;
      bus.rf_wd = bus.wb_data;
    end else if (w_pop) begin
      bus.rf_we = 1'b1;
      bus.rf_a3 = w_head.rd;
      bus.rf_wd = w_head.data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       r_wait <= '0;
    else if (w_empty || w_pop)         r_wait <= '0;
    else if (r_wait != WW'(MAX_WAIT))  r_wait <= r_wait + 1'b1;
  end

`ifdef KIANV_RF_SCOREBOARD_EN
  logic [REGISTER_DEPTH-1:0] r_pending;
  logic [REGISTER_DEPTH-1:0] w_set;
  logic [REGISTER_DEPTH-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < REGISTER_DEPTH; i++) begin
      w_set[i] = bus.lu_issue_valid && (bus.lu_issue_rd != RF_X0) &&
                 (bus.lu_issue_rd == rf_addr_t'(i));
      w_clr[i] = w_pop && (w_head.rd == rf_addr_t'(i));
    end
  end

  // A re-issue in the very cycle the old result retires is fine; set wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pending <= '0;
    else         r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign bus.pending_mask = r_pending;

  a_no_double_issue: assert property (@(posedge clk) disable iff (!resetn)
    (bus.lu_issue_valid && bus.lu_issue_rd != RF_X0) |->
    (!r_pending[bus.lu_issue_rd] || w_clr[bus.lu_issue_rd]));
`else
  logic w_unused_issue;
  assign w_unused_issue   = ^{bus.lu_issue_valid, bus.lu_issue_rd};
  assign bus.pending_mask = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected RF writes, a negedge
// monitor pops and compares every write the DUT makes.
module tb_regfile_wb_arbiter;
  import kianv_rf_pkg::*;

  localparam int RD = 32;
  localparam int FD = 2;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.REGISTER_DEPTH(RD)) bus ();

  regfile_wb_arbiter #(.REGISTER_DEPTH(RD), .FIFO_DEPTH(FD), .MAX_WAIT(MW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  rf_wr_req_t exp_q [$];
  rf_wr_req_t mon_e;
  int n_chk  = 0;
  int n_pass = 0;
  int k;
  int s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wb_valid       = 1'b0;
    bus.wb_rd          = '0;
    bus.wb_data        = '0;
    bus.lu_valid       = 1'b0;
    bus.lu_rd          = '0;
    bus.lu_data        = '0;
    bus.lu_issue_valid = 1'b0;
    bus.lu_issue_rd    = '0;
  endtask

  task automatic wexp(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  // Monitor: every RF write must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                 bus.rf_a3, bus.rf_wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_rd", 32'(bus.rf_a3), 32'(mon_e.rd));
        chk("write_data", bus.rf_wd, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    smp();
    chk("reset_rf_we", 32'(bus.rf_we), 0);
    chk("reset_wb_stall", 32'(bus.wb_stall), 0);
    chk("reset_lu_ready", 32'(bus.lu_ready), 1);
    chk("reset_mask", bus.pending_mask, 0);

    // Writeback with empty FIFO: same-cycle write.
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    wexp(5'd5, 32'hDEADBEEF);
    smp();
    chk("t1_lu_ready", 32'(bus.lu_ready), 1);
    chk("t1_rf_we", 32'(bus.rf_we), 1);

    // Writeback to x0 is suppressed.
    tick();
    bus.wb_rd = 5'd0; bus.wb_data = 32'h77;
    smp();
    chk("wb_x0_we", 32'(bus.rf_we), 0);

    // LU result is written the cycle after the handshake.
    tick();
    bus.wb_valid = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h11;
    wexp(5'd7, 32'h11);
    smp();
    chk("t2_lu_ready", 32'(bus.lu_ready), 1);
    chk("t2_no_passthru", 32'(bus.rf_we), 0);
    tick();
    bus.lu_valid = 1'b0;
    smp();
    chk("t2_lu_write", 32'(bus.rf_we), 1);
    tick();
    smp();
    chk("t2_drained", 32'(bus.rf_we), 0);

    // LU result to x0: handshaken, never written.
    tick();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'h55;
    smp();
    chk("t5_lu_ready", 32'(bus.lu_ready), 1);
    tick();
    bus.lu_valid = 1'b0;
    smp();
    chk("t5_rf_we", 32'(bus.rf_we), 0);
    chk("t5_lu_ready2", 32'(bus.lu_ready), 1);

    // Starvation: stall exactly once, when the head has waited MAX_WAIT cycles.
    k = 0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd10; bus.wb_data = 32'hA0 + k;
      bus.lu_valid = (i == 0); bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
      if (i == 5) wexp(5'd9, 32'h99);
      else        wexp(5'd10, 32'hA0 + k);
      smp();
      chk("t3_stall", 32'(bus.wb_stall), (i == 5) ? 1 : 0);
      if (i != 5) k++;
    end

    // Fill FIFO under constant writeback; third result held until space frees.
    k = 0;
    s = 0;
    for (int i = 0; i <= 16; i++) begin
      tick();
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd11; bus.wb_data = 32'hB00 + k;
      bus.lu_valid = (i <= 6);
      bus.lu_rd    = (i == 0) ? 5'd12 : (i == 1) ? 5'd13 : 5'd14;
      bus.lu_data  = (i == 0) ? 32'hC0 : (i == 1) ? 32'hC1 : 32'hC2;
      if (i == 5 || i == 10 || i == 15) begin
        wexp(5'(12 + s), 32'hC0 + s);
        s++;
      end else begin
        wexp(5'd11, 32'hB00 + k);
        k++;
      end
      smp();
      chk("t4_stall", 32'(bus.wb_stall), (i == 5 || i == 10 || i == 15) ? 1 : 0);
      chk("t4_lu_ready", 32'(bus.lu_ready), (i <= 1 || i == 6 || i >= 11) ? 1 : 0);
    end
    tick();
    idle();
    smp();
    chk("t4_drained", 32'(bus.rf_we), 0);

`ifdef KIANV_RF_SCOREBOARD_EN
    tick();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd3;
    smp();
    chk("sb_before_set", bus.pending_mask, 0);
    tick();
    bus.lu_issue_valid = 1'b0;
    smp();
    chk("sb_set3", bus.pending_mask, 32'h8);
    tick();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 32'h33;
    wexp(5'd3, 32'h33);
    smp();
    chk("sb_queued3", bus.pending_mask, 32'h8);
    tick();
    bus.lu_valid = 1'b0;
    smp();
    chk("sb_grant3_we", 32'(bus.rf_we), 1);
    chk("sb_grant3_mask", bus.pending_mask, 32'h8);
    tick();
    smp();
    chk("sb_clr3", bus.pending_mask, 0);
    tick();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd4;
    smp();
    tick();
    bus.lu_issue_valid = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd4; bus.lu_data = 32'h44;
    wexp(5'd4, 32'h44);
    smp();
    chk("sb_set4", bus.pending_mask, 32'h10);
    tick();
    bus.lu_valid = 1'b0;
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd4;
    smp();
    tick();
    bus.lu_issue_valid = 1'b0;
    smp();
    chk("sb_set_wins", bus.pending_mask, 32'h10);
`else
    tick();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd3;
    smp();
    tick();
    bus.lu_issue_valid = 1'b0;
    smp();
    chk("mask_tied0", bus.pending_mask, 0);
`endif

    // Reset with results still queued.
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd11; bus.wb_data = 32'hE0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd20; bus.lu_data = 32'h200;
    wexp(5'd11, 32'hE0);
    smp();
    tick();
    bus.wb_data = 32'hE1;
    bus.lu_rd = 5'd21; bus.lu_data = 32'h210;
    wexp(5'd11, 32'hE1);
    smp();
    tick();
    idle();
    #1 resetn = 1'b0;
    smp();
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_lu_ready", 32'(bus.lu_ready), 1);
    chk("rst_wb_stall", 32'(bus.wb_stall), 0);
    chk("rst_mask", bus.pending_mask, 0);
    tick();
    resetn = 1'b1;
    smp();
    chk("post_rst_empty", 32'(bus.rf_we), 0);
    chk("post_rst_ready", 32'(bus.lu_ready), 1);

    tick();
    smp();
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
